johnson_counter_param: RTL



---
 rtl/johnson_counter_param.sv | 61 ++++++
 1 files changed

// File: rtl/johnson_counter_param.sv
// johnson_counter_param: twisted-ring counter with enable, direction, load,
// illegal-code self-correction, phase index decode and wrap/err pulses.
module johnson_counter_param #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_err;
    logic [WIDTH-2:0] w_diff;
    logic             w_legal;
    logic [WIDTH-1:0] w_fwd;
    logic [WIDTH-1:0] w_rev;
    logic [PW-1:0]    w_ones;
    logic             w_wrap;

    // A legal code has at most one boundary between adjacent bits.
    assign w_diff  = r_count[WIDTH-2:0] ^ r_count[WIDTH-1:1];
    assign w_legal = (w_diff & (w_diff - 1'b1)) == '0;
    assign w_fwd   = {~r_count[0], r_count[WIDTH-1:1]};
    assign w_rev   = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < WIDTH; i++) w_ones = w_ones + PW'(r_count[i]);
    end

    // Ones-first codes index by their ones count; zeros-first codes count down from 2*WIDTH.
    assign phase = !w_legal ? '0 :
                   r_count[WIDTH-1] ? w_ones :
                   (w_ones == '0) ? '0 : PW'(2 * WIDTH - int'(w_ones));

    assign w_wrap = !load && w_legal && en && (up_dn ? (w_fwd == '0) : (r_count == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= load ? load_val : !w_legal ? '0 : en ? (up_dn ? w_fwd : w_rev) : r_count;
            r_wrap  <= w_wrap;
            r_err   <= !load && !w_legal;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign err   = r_err;
endmodule
